// File: rtl/d_pipe_pkg.sv
// Shared constants and helpers for the d_pipe register pipeline.
package d_pipe_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 4;

    // Width of the occupancy counter: enough bits to hold 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One pipeline stage: a data register plus its valid bit, loaded when enabled.
module d_pipe_stage
    import d_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data is deliberately not reset; only the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= in_data;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/d_pipe.sv
// Valid/ready register pipeline of DEPTH stages with bubble collapse, flush and
// a registered occupancy count.
module d_pipe
    import d_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [WIDTH-1:0] src_data   [DEPTH];
    logic [CntW-1:0]  count_q, count_d;

    // A stage can accept when it is empty or its contents move on this edge.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            rdy[i] = !stage_v[i] || rdy[i+1];
        end
    end

    assign in_ready = rdy[0] && !flush;

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        if (g == 0) begin : g_head
            assign src_data[g] = in_data;
            assign src_v[g]    = in_valid && !flush;
        end else begin : g_body
            assign src_data[g] = stage_data[g-1];
            assign src_v[g]    = stage_v[g-1];
        end

        d_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (rdy[g]),
            .in_data  (src_data[g]),
            .in_valid (src_v[g]),
            .out_data (stage_data[g]),
            .out_valid(stage_v[g])
        );
    end

    // Mirror of the stages' next valid bits, used only to register the popcount.
    always_comb begin
        v_d     = stage_v;
        count_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (rdy[i]) begin
                v_d[i] = src_v[i];
            end
            count_d = count_d + CntW'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign out_valid = stage_v[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

endmodule
